// File: rtl/neuron_input_loader.sv
// neuron_input_loader: stream-to-parallel sample loader for one neuron; define LOADER_FRAME_CHECK_EN to add in_last_i/frame_error_o framing checks
module neuron_input_loader #(
  parameter int NUM_INPUTS = 120,
  parameter int INTEGER_WIDTH = 8,
  parameter int FRACTION_WIDTH = 8,
  localparam int W = INTEGER_WIDTH + FRACTION_WIDTH,
  localparam int CW = $clog2(NUM_INPUTS)
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic signed [W-1:0] in_data_i,
  output logic signed [W-1:0] inputs_o [NUM_INPUTS],
  output logic                inputs_ready_o,
`ifdef LOADER_FRAME_CHECK_EN
  input  logic                in_last_i,
  output logic                frame_error_o,
`endif
  input  logic                output_ready_i
);
  typedef enum logic [1:0] {LOAD = 2'd0, PRESENT = 2'd1, RELEASE = 2'd2} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic inputs_ready_q, inputs_ready_d;
  logic live_q;
  logic signed [W-1:0] inputs_q [NUM_INPUTS];
  logic beat, at_end, done, clear;
  assign at_end = count_q == CW'(NUM_INPUTS - 1);
  assign beat = in_valid_i & in_ready_o;
`ifdef LOADER_FRAME_CHECK_EN
  logic frame_error_q, frame_error_d;
  assign done = beat & (at_end | in_last_i);
  assign frame_error_d = beat & (at_end ^ in_last_i);
  assign frame_error_o = frame_error_q;
  // one-cycle pulse when a frame closes at the wrong beat
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) frame_error_q <= 1'b0;
    else frame_error_q <= frame_error_d;
`else
  assign done = beat & at_end;
`endif
  assign clear = (state_q == RELEASE) & ~output_ready_i;
  assign inputs_o = inputs_q;
  assign inputs_ready_o = inputs_ready_q;
  // state register plus counter and presentation flag; live_q keeps in_ready low until the first clock after reset
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      state_q <= LOAD;
      count_q <= '0;
      inputs_ready_q <= 1'b0;
      live_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      inputs_ready_q <= inputs_ready_d;
      live_q <= 1'b1;
    end
  // next state: fill, present until the neuron answers, then wait for it to go idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    state_d = done ? PRESENT : LOAD;
      PRESENT: state_d = output_ready_i ? RELEASE : PRESENT;
      RELEASE: state_d = output_ready_i ? RELEASE : LOAD;
      default: state_d = LOAD;
    endcase
  end
  // outputs and next values of the counter and presentation flag
  always_comb begin
    in_ready_o = live_q & (state_q == LOAD);
    count_d = beat ? (done ? '0 : count_q + CW'(1)) : count_q;
    inputs_ready_d = state_d == PRESENT;
  end
  // sample array: write on each beat, wipe on leaving RELEASE so short frames read back as zero
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) for (int i = 0; i < NUM_INPUTS; i++) inputs_q[i] <= '0;
    else if (clear) for (int i = 0; i < NUM_INPUTS; i++) inputs_q[i] <= '0;
    else if (beat) inputs_q[count_q] <= in_data_i;
endmodule

// File: tb/tb_neuron_input_loader.sv
// tb_neuron_input_loader: directed tables, corner sequences and a random run against a queue-based model
module tb_neuron_input_loader;
  localparam int N = 120;
  localparam int W = 16;
  typedef logic signed [W-1:0] smp_t;
  typedef struct {
    logic v;
    logic ordy;
    logic e_in_ready;
    logic e_inputs_ready;
    int   e_arr;
  } vec_t;
  logic clk = 0, rst = 1, in_valid = 0, output_ready = 0;
  smp_t in_data = '0;
  logic in_ready, inputs_ready;
  smp_t arr [N];
`ifdef LOADER_FRAME_CHECK_EN
  logic in_last = 0, frame_error;
`endif
  int checks = 0, failures = 0;
  smp_t zeros [N], frame1 [N], frame2 [N], vals [N], view [N];
  smp_t got [$];
  bit pres, rel;
  vec_t vt [9];

  neuron_input_loader #(.NUM_INPUTS(N), .INTEGER_WIDTH(8), .FRACTION_WIDTH(8)) dut (
    .clock_i(clk), .reset_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .inputs_o(arr), .inputs_ready_o(inputs_ready),
`ifdef LOADER_FRAME_CHECK_EN
    .in_last_i(in_last), .frame_error_o(frame_error),
`endif
    .output_ready_i(output_ready));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_arr(input string name, input smp_t e [N]);
    int bad = -1;
    for (int i = 0; i < N; i++) if (arr[i] !== e[i] && bad < 0) bad = i;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s idx=%0d actual=%0h required=%0h", name, bad, arr[bad], e[bad]);
    end
  endtask

  task automatic send_frame(input smp_t v [N], input int nbeats, input bit or_last, input bit mark_last);
    for (int i = 0; i < nbeats; i++) begin
      in_valid = 1;
      in_data = v[i];
      output_ready = or_last && i == nbeats - 1;
`ifdef LOADER_FRAME_CHECK_EN
      in_last = mark_last && i == nbeats - 1;
`endif
      step();
      if (i == nbeats - 2) chk("ir_before_last", inputs_ready, 0);
    end
    in_valid = 0;
    output_ready = 0;
`ifdef LOADER_FRAME_CHECK_EN
    in_last = 0;
`endif
  endtask

  task automatic release_frame();
    output_ready = 1;
    step();
    output_ready = 0;
    step();
    chk("release_in_ready", in_ready, 1);
  endtask

  task automatic apply_vec(input int k);
    in_valid = vt[k].v;
    in_data = 16'sh1234;
    output_ready = vt[k].ordy;
    step();
    chk("vec_in_ready", in_ready, vt[k].e_in_ready);
    chk("vec_inputs_ready", inputs_ready, vt[k].e_inputs_ready);
    chk_arr("vec_arr", vt[k].e_arr == 0 ? zeros : vt[k].e_arr == 1 ? frame1 : frame2);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      zeros[i] = '0;
      frame1[i] = 16'sh0300;
      frame2[i] = 16'shFE80;
    end
    vt[0] = '{0, 1, 0, 0, 1};
    vt[1] = '{1, 0, 1, 0, 0};
    for (int k = 2; k < 7; k++) vt[k] = '{0, 1, 0, 0, 2};
    vt[7] = '{0, 0, 1, 0, 0};
    vt[8] = '{0, 1, 1, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_inputs_ready", inputs_ready, 0);
    chk_arr("rst_arr", zeros);
`ifdef LOADER_FRAME_CHECK_EN
    chk("rst_frame_error", frame_error, 0);
`endif
    rst = 0;
    #2;
    chk("in_ready_before_first_clk", in_ready, 0);
    step();
    chk("in_ready_after_first_clk", in_ready, 1);
    send_frame(frame1, N, 0, 1);
    chk("f1_inputs_ready", inputs_ready, 1);
    chk("f1_in_ready", in_ready, 0);
    chk_arr("f1_arr", frame1);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1;
      in_data = smp_t'($urandom);
      step();
      chk("hold_inputs_ready", inputs_ready, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 0;
    chk_arr("hold_arr", frame1);
    for (int k = 0; k < 2; k++) apply_vec(k);
    in_valid = 0;
    send_frame(frame2, N, 1, 1);
    chk("f2_inputs_ready", inputs_ready, 1);
    chk_arr("f2_arr", frame2);
    step();
    chk("f2_or_on_last_ignored", inputs_ready, 1);
    for (int k = 2; k < 9; k++) apply_vec(k);
    output_ready = 0;
    for (int i = 0; i < N; i++) vals[i] = smp_t'($urandom);
    send_frame(vals, 60, 0, 0);
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_inputs_ready", inputs_ready, 0);
    chk_arr("midrst_arr", zeros);
    step();
    rst = 0;
    step();
    chk("postrst_in_ready", in_ready, 1);
    send_frame(vals, N, 0, 1);
    chk("postrst_inputs_ready", inputs_ready, 1);
    chk_arr("postrst_arr", vals);
    release_frame();
`ifdef LOADER_FRAME_CHECK_EN
    send_frame(vals, 50, 0, 1);
    for (int i = 0; i < N; i++) view[i] = i < 50 ? vals[i] : '0;
    chk("short_inputs_ready", inputs_ready, 1);
    chk("short_frame_error", frame_error, 1);
    chk_arr("short_arr", view);
    step();
    chk("short_error_pulse_end", frame_error, 0);
    release_frame();
    send_frame(vals, N, 0, 1);
    chk("good_frame_error", frame_error, 0);
    chk("good_inputs_ready", inputs_ready, 1);
    release_frame();
    send_frame(vals, N, 0, 0);
    chk("nolast_frame_error", frame_error, 1);
    release_frame();
`endif
    pres = 0;
    rel = 0;
    got.delete();
    for (int c = 0; c < 3000; c++) begin
      logic v, o;
      bit acc;
      smp_t d;
      v = $urandom_range(0, 9) < 7;
      o = $urandom_range(0, 4) == 0;
      d = smp_t'($urandom);
      acc = !pres && !rel;
      in_valid = v;
      in_data = d;
      output_ready = o;
`ifdef LOADER_FRAME_CHECK_EN
      in_last = got.size() == N - 1;
`endif
      step();
      if (acc && v) begin
        got.push_back(d);
        if (got.size() == N) begin
          for (int i = 0; i < N; i++) frame1[i] = got[i];
          got.delete();
          pres = 1;
        end
      end else if (pres && o) begin
        pres = 0;
        rel = 1;
      end else if (rel && !o) rel = 0;
      for (int i = 0; i < N; i++) view[i] = (pres || rel) ? frame1[i] : (i < got.size() ? got[i] : '0);
      chk("rnd_in_ready", in_ready, !pres && !rel);
      chk("rnd_inputs_ready", inputs_ready, pres);
      chk_arr("rnd_arr", view);
`ifdef LOADER_FRAME_CHECK_EN
      chk("rnd_frame_error", frame_error, 0);
`endif
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
